// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding, default sync marker and bit timing
// common to the receiver, transmitter and framer.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT   = 217;
    localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DRAIN   = 3'd4
    } framer_state_t;

endpackage

// File: rtl/uart_rx_framer_sat_cnt8.sv
// 8-bit saturating event counter with synchronous clear; holds at 8'hFF.
`timescale 1ns/1ps
module sat_cnt8 (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_rx_framer.sv
// Frames the UART byte stream (SYNC, LEN, payload, CHK), validates length and XOR
// checksum, and replays good payloads on a registered valid/ready stream with last.
`timescale 1ns/1ps
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 4340
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] chk_err_cnt,
    output logic [7:0] len_err_cnt,
    output logic [7:0] tmo_err_cnt,
    output logic [7:0] drop_cnt
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
    localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] IDLE_MAX = TMO_W'(TIMEOUT_CLKS - 1);

    framer_state_t    r_state;
    logic [7:0]       r_buf [MAX_LEN];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] r_last_idx;
    logic [7:0]       r_chk;
    logic [TMO_W-1:0] r_idle;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_last;

    logic             w_in_frame;
    logic             w_idle_max;
    logic             w_len_ok;
    logic             w_buf_we;
    logic [IDX_W-1:0] w_rd_next;
    logic             w_inc_len;
    logic             w_inc_chk;
    logic             w_inc_tmo;
    logic             w_inc_drop;

    assign w_in_frame = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
    assign w_idle_max = (r_idle == IDLE_MAX);
    assign w_len_ok   = (rx_byte >= 8'd1) && (rx_byte <= 8'(MAX_LEN));
    assign w_buf_we   = (r_state == PAYLOAD) && rx_dv;
    assign w_rd_next  = r_rd_idx + IDX_W'(1);

    assign w_inc_len  = (r_state == LEN) && rx_dv && !w_len_ok;
    assign w_inc_chk  = (r_state == CHK) && rx_dv && (rx_byte != r_chk);
    assign w_inc_tmo  = w_in_frame && !rx_dv && w_idle_max;
    assign w_inc_drop = (r_state == DRAIN) && rx_dv;

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx[AW-1:0]] <= rx_byte;
        end
    end

    // The stored length is kept as its last index so wr/rd compares need no subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_last_idx  <= '0;
            r_chk       <= '0;
            r_idle      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_in_frame) begin
                r_idle <= (rx_dv || w_idle_max) ? '0 : r_idle + TMO_W'(1);
            end
            case (r_state)
                HUNT: begin
                    if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                        r_idle  <= '0;
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    if (rx_dv) begin
                        if (w_len_ok) begin
                            r_last_idx <= rx_byte[IDX_W-1:0] - IDX_W'(1);
                            r_chk      <= rx_byte;
                            r_wr_idx   <= '0;
                            r_state    <= PAYLOAD;
                        end else begin
                            r_state <= HUNT;
                        end
                    end else if (w_idle_max) begin
                        r_state <= HUNT;
                    end
                end
                PAYLOAD: begin
                    if (rx_dv) begin
                        r_chk <= r_chk ^ rx_byte;
                        if (r_wr_idx == r_last_idx) begin
                            r_state <= CHK;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end else if (w_idle_max) begin
                        r_state <= HUNT;
                    end
                end
                CHK: begin
                    if (rx_dv) begin
                        if (rx_byte == r_chk) begin
                            r_rd_idx    <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_buf[0];
                            r_out_last  <= (r_last_idx == '0);
                            r_state     <= DRAIN;
                        end else begin
                            r_state <= HUNT;
                        end
                    end else if (w_idle_max) begin
                        r_state <= HUNT;
                    end
                end
                DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= HUNT;
                        end else begin
                            r_rd_idx   <= w_rd_next;
                            r_out_data <= r_buf[w_rd_next[AW-1:0]];
                            r_out_last <= (w_rd_next == r_last_idx);
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= HUNT;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    sat_cnt8 u_chk_err_cnt (.i_clk(clk), .i_clr(rst), .i_inc(w_inc_chk),  .o_cnt(chk_err_cnt));
    sat_cnt8 u_len_err_cnt (.i_clk(clk), .i_clr(rst), .i_inc(w_inc_len),  .o_cnt(len_err_cnt));
    sat_cnt8 u_tmo_err_cnt (.i_clk(clk), .i_clr(rst), .i_inc(w_inc_tmo),  .o_cnt(tmo_err_cnt));
    sat_cnt8 u_drop_cnt    (.i_clk(clk), .i_clr(rst), .i_inc(w_inc_drop), .o_cnt(drop_cnt));

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: directed frame scenarios plus randomized frames
// whose expected payloads and error counts come from the frame rules, not the RTL.
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int unsigned MAX_LEN      = 16;
    localparam int unsigned TIMEOUT_CLKS = 4340;
    localparam logic [7:0]  SYNC         = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] chk_err_cnt, len_err_cnt, tmo_err_cnt, drop_cnt;

    uart_rx_framer #(
        .SYNC_BYTE(SYNC),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .chk_err_cnt(chk_err_cnt), .len_err_cnt(len_err_cnt),
        .tmo_err_cnt(tmo_err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned handshakes = 0;
    int unsigned ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 hold low
    logic [8:0]  sb[$];           // {last, data}
    logic [7:0]  tx_q[$];
    int unsigned m_chk = 0, m_len = 0, m_tmo = 0, m_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_counters(input string name);
        check({name, ".chk_err_cnt"}, 32'(chk_err_cnt), 32'(m_chk));
        check({name, ".len_err_cnt"}, 32'(len_err_cnt), 32'(m_len));
        check({name, ".tmo_err_cnt"}, 32'(tmo_err_cnt), 32'(m_tmo));
        check({name, ".drop_cnt"},    32'(drop_cnt),    32'(m_drop));
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_q(input int unsigned gmin, input int unsigned gmax);
        while (tx_q.size() != 0) send_byte(tx_q.pop_front(), $urandom_range(gmax, gmin));
    endtask

    // Expected good-frame output: every payload byte, last flag on the final one.
    task automatic expect_payload(input logic [7:0] p[$]);
        for (int i = 0; i < p.size(); i++) sb.push_back({(i == p.size() - 1), p[i]});
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk); n++;
        end
        @(negedge clk);
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, sb.size());
        end
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        m_chk = 0; m_len = 0; m_tmo = 0; m_drop = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per handshake and checks stall stability.
    logic       stalled = 1'b0;
    logic [8:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", 32'(out_valid), 32'd1);
                check("stall_data_held", 32'({out_last, out_data}), 32'(held));
            end
            if (out_valid === 1'b1 && sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_out: data 0x%0h last %0b with nothing expected", out_data, out_last);
            end
            if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
                check("out_byte", 32'({out_last, out_data}), 32'(sb.pop_front()));
                handshakes++;
                stalled = 1'b0;
            end else if (out_valid === 1'b1 && !out_ready) begin
                stalled = 1'b1;
                held = {out_last, out_data};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  p[$];
        logic [7:0]  ck;
        logic [7:0]  b;
        int unsigned len, kind, hs0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_last", 32'(out_last), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check_counters("reset");

        // Good frame at line-rate spacing; first valid right after the CHK pulse.
        ready_mode = 0;
        p = '{8'h11, 8'h22, 8'h33};
        expect_payload(p);
        tx_q = '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_q(2170, 2170);
        check("good.first_valid", 32'(out_valid), 32'd1);
        check("good.first_data", 32'(out_data), 32'h11);
        wait_drain("good");
        check_counters("good");

        // Backpressure: toggling ready, exactly three handshakes.
        ready_mode = 1;
        hs0 = handshakes;
        expect_payload(p);
        tx_q = '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_q(3, 3);
        wait_drain("backpressure");
        check("backpressure.handshakes", 32'(handshakes - hs0), 32'd3);

        // Bad checksum, then SYNC as payload data.
        ready_mode = 0;
        tx_q = '{SYNC, 8'h02, 8'h10, 8'h20, 8'h31};
        send_q(1, 4);
        m_chk++;
        repeat (4) @(posedge clk);
        check_counters("bad_chk");
        p = '{SYNC};
        expect_payload(p);
        tx_q = '{SYNC, 8'h01, SYNC, 8'hA4};
        send_q(1, 4);
        wait_drain("sync_in_payload");

        // Length errors, then a good frame.
        tx_q = '{SYNC, 8'h00, SYNC, 8'h11};
        send_q(1, 4);
        m_len += 2;
        repeat (4) @(posedge clk);
        check_counters("len_err");
        p = '{8'h5A, 8'hC3};
        expect_payload(p);
        tx_q = '{SYNC, 8'h02, 8'h5A, 8'hC3, 8'h02 ^ 8'h5A ^ 8'hC3};
        send_q(0, 3);
        wait_drain("after_len_err");

        // Inter-byte timeout; the late tail must be ignored in HUNT.
        tx_q = '{SYNC, 8'h03, 8'h11};
        send_q(1, 2);
        repeat (TIMEOUT_CLKS + 10) @(posedge clk);
        m_tmo++;
        check_counters("timeout");
        tx_q = '{8'h22, 8'h33, 8'h03};
        send_q(1, 2);
        repeat (20) @(posedge clk);
        check_counters("timeout_tail");

        // Drops during a stalled DRAIN, then reset mid-DRAIN.
        ready_mode = 3;
        p = '{8'h44, 8'h55};
        expect_payload(p);
        tx_q = '{SYNC, 8'h02, 8'h44, 8'h55, 8'h13};
        send_q(0, 2);
        tx_q = '{SYNC, 8'h77};
        send_q(1, 3);
        m_drop += 2;
        repeat (3) @(posedge clk);
        check("drop.valid_held", 32'(out_valid), 32'd1);
        check_counters("drop");
        rst_pulse();
        check("rst_mid_drain.out_valid", 32'(out_valid), 32'd0);
        check_counters("rst_mid_drain");
        ready_mode = 0;
        p = '{8'h01, 8'h02, 8'h03, 8'h04};
        expect_payload(p);
        tx_q = '{SYNC, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04};
        send_q(0, 2);
        wait_drain("after_reset");

        // Randomized frames with random backpressure and leading noise.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                b = 8'($urandom_range(255, 0));
                if (b == SYNC) b = 8'h00;
                tx_q.push_back(b);
            end
            kind = $urandom_range(9, 0);
            len = $urandom_range(MAX_LEN, 1);
            if (f == 0) len = MAX_LEN;
            if (f == 1) len = 1;
            p.delete();
            ck = 8'(len);
            for (int i = 0; i < int'(len); i++) begin
                p.push_back(8'($urandom_range(255, 0)));
                ck = ck ^ p[i];
            end
            tx_q.push_back(SYNC);
            if (kind < 7 || f < 2) begin
                tx_q.push_back(8'(len));
                for (int i = 0; i < int'(len); i++) tx_q.push_back(p[i]);
                tx_q.push_back(ck);
                expect_payload(p);
            end else if (kind < 9) begin
                tx_q.push_back(8'(len));
                for (int i = 0; i < int'(len); i++) tx_q.push_back(p[i]);
                tx_q.push_back(ck ^ 8'($urandom_range(255, 1)));
                m_chk++;
            end else begin
                tx_q.push_back(($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, MAX_LEN + 1)));
                m_len++;
            end
            send_q(0, 12);
            wait_drain("random_frame");
        end
        check_counters("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Consumes the byte stream produced by the UART receiver (one-cycle valid pulse plus byte).
- Delineates frames of the form SYNC, LEN, payload, CHK, and checks length and checksum.
- Buffers the payload and presents validated payloads downstream on a valid/ready byte stream with a last marker.
- Sits between the UART receiver and the order/message decode logic, in the receiver's clock domain.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; legal LEN is 1..MAX_LEN.
- TIMEOUT_CLKS, 4340, idle clocks allowed between bytes inside a frame before abort (about 2 byte times at 217 clocks/bit).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- rx_dv  in  1  one-cycle pulse: rx_byte valid.
- rx_byte  in  8  received byte.
- out_valid  out  1  payload byte available.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_data  out  8  payload byte.
- out_last  out  1  high with the final payload byte of a frame.
- chk_err_cnt  out  8  saturating count of checksum failures.
- len_err_cnt  out  8  saturating count of LEN==0 or LEN>MAX_LEN.
- tmo_err_cnt  out  8  saturating count of inter-byte timeouts.
- drop_cnt  out  8  saturating count of bytes arriving during DRAIN.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. rst has priority over every other event, including mid-frame and mid-drain.
- Reset values:
  - all outputs and counters are 0;
  - state = HUNT;
  - buffer contents are don't-care.
- States HUNT, LEN, PAYLOAD, CHK, DRAIN; every transition is on a clk edge.
- HUNT:
  - on rx_dv with rx_byte==SYNC_BYTE, go to LEN;
  - any other byte is ignored and not counted.
- LEN, on rx_dv:
  - if 1<=rx_byte<=MAX_LEN: store len, set running checksum = rx_byte, set wr_idx = 0, go to PAYLOAD;
  - otherwise: increment len_err_cnt and go to HUNT.
- PAYLOAD, on rx_dv:
  - write buf[wr_idx] = rx_byte and XOR rx_byte into the checksum;
  - when wr_idx == len-1, go to CHK; otherwise wr_idx++.
  - A SYNC_BYTE value inside the payload is data, not a resync.
- CHK, on rx_dv:
  - if rx_byte == checksum: set rd_idx = 0 and go to DRAIN;
  - otherwise: increment chk_err_cnt and go to HUNT.
- Checksum definition: XOR of LEN and all payload bytes, 8-bit.
- Inter-byte timeout:
  - applies in LEN, PAYLOAD and CHK;
  - the idle counter clears on entry to each of these states and on every rx_dv, and increments on all other cycles;
  - when it reaches TIMEOUT_CLKS-1 with no rx_dv that cycle: increment tmo_err_cnt, go to HUNT;
  - if rx_dv arrives on the same cycle as the timeout, the byte wins and there is no timeout.
- DRAIN:
  - out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == len-1);
  - on handshake, rd_idx++; the handshake on out_last goes to HUNT with out_valid low next cycle;
  - out_data and out_last are held stable while out_valid && !out_ready.
  - Output outputs are registered. The first out_valid is high on the cycle after the CHK byte's rx_dv.
  - Any rx_dv during DRAIN is dropped: increment drop_cnt, with no parse. This includes a SYNC_BYTE; a frame starting during DRAIN is lost.
  - Throughput: one byte per clock when out_ready is held high.
- Outside DRAIN, out_valid = 0.
- All counters saturate at 8'hFF.
- Widths:
  - wr_idx, rd_idx and len: $clog2(MAX_LEN+1) bits;
  - idle counter: $clog2(TIMEOUT_CLKS) bits.
- Buffer is a MAX_LEN x 8 register array with a single write port and a single read port; no simultaneous write/read is possible.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (HUNT=0 .. DRAIN=4);
  - the default SYNC_BYTE;
  - the CLKS_PER_BIT value shared with the UART receiver and transmitter.
- One natural sub-module, sat_cnt8: 8-bit saturating incrementer with synchronous clear, instantiated four times for the error and drop counters.
- Buffer and FSM stay inline.

Test Plan:
- Good frame: rx A5 03 11 22 33 03 (bytes about 2170 clocks apart), out_ready=1 -> out stream 11, 22, 33 with out_last only on 33; first out_valid on the cycle after the 03 checksum pulse; all counters stay 0.
- Backpressure: same frame, out_ready toggled 0/1 each cycle -> each byte held stable while stalled; same 11, 22, 33 order; exactly three handshakes.
- Bad checksum, then recovery:
  - A5 02 10 20 31 -> no out_valid, chk_err_cnt=1;
  - then A5 01 A5 A4 -> single byte A5 with out_last, which proves SYNC inside the payload is data.
- Length errors: A5 00 and A5 11 (17 > MAX_LEN) -> len_err_cnt=2, no output; FSM back in HUNT, and a following good frame passes.
- Timeout: A5 03 11, then silence for TIMEOUT_CLKS -> tmo_err_cnt=1, state HUNT; a late 22 33 03 produces no output.
- Drop and reset:
  - good frame, out_ready=0 held, two rx bytes arrive during DRAIN -> drop_cnt=2;
  - rst pulse mid-DRAIN -> next cycle out_valid=0, all counters 0, and the next frame parses normally.
